// File: rtl/mcpu_scanout.sv
// Framebuffer scanout: on each hsync_in rise, fetches the next visible row (16 words)
// into a line buffer, then emits one registered 4-bit pixel per cycle with aligned syncs.
module mcpu_scanout #(
   parameter logic [11:0] FB_BASE        = 12'h800,
   parameter int          V_DISPLAY      = 240,
   parameter int          V_TOTAL        = 262,
   parameter logic [3:0]  UNDERRUN_COLOR = 4'hc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  hpos,
   input  logic [8:0]  vpos,
   input  logic        display_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic        rd_req,
   output logic [11:0] rd_addr,
   input  logic        rd_ack,
   input  logic [31:0] rd_data,
   output logic [3:0]  rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        underrun
);

   typedef enum logic {IDLE, FETCH} state_t;

   localparam logic [8:0] V_DISPLAY_W = 9'(V_DISPLAY);
   localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);

   state_t      state_q, state_d;
   logic [3:0]  word_cnt_q, word_cnt_d;
   logic [6:0]  row_q, row_d;
   logic [15:0] valid_q, valid_d;
   logic [31:0] line_buf_q [16];
   logic [31:0] line_buf_d [16];
   logic        hsync_prev_q;
   logic        display_prev_q;
   logic [3:0]  rgb_q, rgb_d;
   logic        hsync_q, vsync_q;
   logic        underrun_q, underrun_d;

   logic [8:0]  next_v;
   logic        fetch_start;
   logic [3:0]  px_word;
   logic [2:0]  px_nib;
   logic [31:0] cur_word;

   assign next_v      = (vpos == V_LAST) ? 9'd0 : vpos + 9'd1;
   assign fetch_start = hsync_in && !hsync_prev_q && (next_v < V_DISPLAY_W);

   // Request outputs derive from registered state so async reset drops them at once
   assign rd_req  = (state_q == FETCH);
   assign rd_addr = (state_q == FETCH) ?
                    FB_BASE + {1'b0, row_q, 4'b0000} + {8'b0, word_cnt_q} : 12'h000;

   // Fetch sequencer: a new trigger always restarts, even mid-fetch
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      row_d      = row_q;
      valid_d    = valid_q;
      line_buf_d = line_buf_q;
      if (fetch_start) begin
         state_d    = FETCH;
         word_cnt_d = 4'd0;
         valid_d    = 16'h0000;
         row_d      = next_v[7:1];
      end else if (state_q == FETCH && rd_ack) begin
         line_buf_d[word_cnt_q] = rd_data;
         valid_d[word_cnt_q]    = 1'b1;
         word_cnt_d             = word_cnt_q + 4'd1;
         if (word_cnt_q == 4'hf) begin
            state_d = IDLE;
         end
      end
   end

   assign px_word  = hpos[7:4];
   assign px_nib   = hpos[3:1];
   assign cur_word = line_buf_q[px_word];

   always_comb begin
      rgb_d      = 4'h0;
      underrun_d = display_on && !display_prev_q && (state_q == FETCH);
      if (display_on) begin
         rgb_d = valid_q[px_word] ? cur_word[{px_nib, 2'b00} +: 4] : UNDERRUN_COLOR;
      end else if (vpos[0] ^ hpos[0]) begin
         rgb_d = 4'hf;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         word_cnt_q     <= 4'd0;
         row_q          <= 7'd0;
         valid_q        <= 16'h0000;
         hsync_prev_q   <= 1'b0;
         display_prev_q <= 1'b0;
         rgb_q          <= 4'h0;
         hsync_q        <= 1'b0;
         vsync_q        <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         word_cnt_q     <= word_cnt_d;
         row_q          <= row_d;
         valid_q        <= valid_d;
         hsync_prev_q   <= hsync_in;
         display_prev_q <= display_on;
         rgb_q          <= rgb_d;
         hsync_q        <= hsync_in;
         vsync_q        <= vsync_in;
         underrun_q     <= underrun_d;
      end
   end

   // Buffer data is never reset; the cleared valid mask hides stale words
   always_ff @(posedge clk) begin
      line_buf_q <= line_buf_d;
   end

   assign rgb      = rgb_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_mcpu_scanout.sv
// Directed bench for mcpu_scanout: table-driven pixel vectors plus hand-written
// sequences for fetch addressing, frame wrap, underrun and mid-fetch reset.
module tb_mcpu_scanout;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [8:0]  hpos = '0;
   logic [8:0]  vpos = '0;
   logic        display_on = 1'b0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic        rd_req;
   logic [11:0] rd_addr;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic [3:0]  rgb;
   logic        hsync;
   logic        vsync;
   logic        underrun;
   logic        ack_en = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [8:0] hpos;
      logic [8:0] vpos;
      logic       display_on;
      logic [3:0] exp_rgb;
   } vec_t;

   vec_t vecs[$];

   mcpu_scanout dut (
      .clk        (clk),
      .reset      (reset),
      .hpos       (hpos),
      .vpos       (vpos),
      .display_on (display_on),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .rd_data    (rd_data),
      .rgb        (rgb),
      .hsync      (hsync),
      .vsync      (vsync),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   // RAM model: word 0 of any row holds 0x76543210, word k holds k in every nibble
   assign rd_ack  = ack_en & rd_req;
   assign rd_data = (rd_addr[3:0] == 4'h0) ? 32'h76543210 : {8{rd_addr[3:0]}};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      hpos       = v.hpos;
      vpos       = v.vpos;
      display_on = v.display_on;
      tick();
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < 16; i++) begin
         v.hpos = 9'(i); v.vpos = 9'd250; v.display_on = 1'b1; v.exp_rgb = 4'(i / 2);
         vecs.push_back(v);
      end
      v.hpos = 9'd32; v.vpos = 9'd250; v.display_on = 1'b1; v.exp_rgb = 4'h2; vecs.push_back(v);
      v.hpos = 9'd3;  v.vpos = 9'd4;   v.display_on = 1'b0; v.exp_rgb = 4'hf; vecs.push_back(v);
      v.hpos = 9'd4;  v.vpos = 9'd4;   v.display_on = 1'b0; v.exp_rgb = 4'h0; vecs.push_back(v);

      // Reset state
      tick();
      tick();
      checkOutput("reset_rd_req", rd_req, 0);
      checkOutput("reset_rd_addr", rd_addr, 0);
      checkOutput("reset_rgb", rgb, 0);
      checkOutput("reset_hsync", hsync, 0);
      checkOutput("reset_vsync", vsync, 0);
      checkOutput("reset_underrun", underrun, 0);
      reset = 1'b1;
      tick();

      // Fetch addressing for vpos=9 -> row 5
      vpos = 9'd9;
      ack_en = 1'b1;
      tick();
      hsync_in = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         checkOutput("fetch_rd_req", rd_req, 1);
         checkOutput("fetch_rd_addr", rd_addr, 32'h850 + i);
         tick();
      end
      checkOutput("fetch_done", rd_req, 0);
      hsync_in = 1'b0;
      ack_en = 1'b0;
      tick();

      // Sync delay; vpos=250 is outside the visible area so no fetch
      vpos = 9'd250;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      tick();
      checkOutput("hsync_delay", hsync, 1);
      checkOutput("vsync_delay", vsync, 1);
      checkOutput("no_fetch_250", rd_req, 0);
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      tick();
      checkOutput("hsync_low", hsync, 0);

      // Pixel mapping and border vectors
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput("pixel_rgb", rgb, vecs[i].exp_rgb);
      end

      // Frame wrap: vpos=261 fetches row 0
      display_on = 1'b0;
      ack_en = 1'b1;
      vpos = 9'd261;
      hsync_in = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         checkOutput("wrap_rd_addr", rd_addr, 32'h800 + i);
         tick();
      end
      checkOutput("wrap_done", rd_req, 0);
      hsync_in = 1'b0;
      vpos = 9'd239;
      tick();
      hsync_in = 1'b1;
      tick();
      checkOutput("no_fetch_239", rd_req, 0);
      tick();
      checkOutput("no_fetch_239_b", rd_req, 0);
      hsync_in = 1'b0;
      ack_en = 1'b0;
      tick();

      // Underrun: acks withheld until display starts
      display_on = 1'b0;
      hpos = 9'd14;
      vpos = 9'd20;
      tick();
      hsync_in = 1'b1;
      tick();
      checkOutput("ur_rd_req", rd_req, 1);
      checkOutput("ur_rd_addr", rd_addr, 32'h8a0);
      tick();
      tick();
      checkOutput("ur_addr_held", rd_addr, 32'h8a0);
      display_on = 1'b1;
      tick();
      checkOutput("ur_pulse", underrun, 1);
      checkOutput("ur_rgb", rgb, 4'hc);
      tick();
      checkOutput("ur_pulse_end", underrun, 0);
      checkOutput("ur_rgb_b", rgb, 4'hc);
      ack_en = 1'b1;
      tick();
      ack_en = 1'b0;
      checkOutput("ur_same_cycle_rgb", rgb, 4'hc);
      checkOutput("ur_next_addr", rd_addr, 32'h8a1);
      tick();
      checkOutput("ur_word_visible", rgb, 4'h7);
      hpos = 9'd16;
      tick();
      checkOutput("ur_unfetched_rgb", rgb, 4'hc);
      display_on = 1'b0;
      hsync_in = 1'b0;
      ack_en = 1'b1;
      for (int i = 0; i < 40 && rd_req; i++) begin
         tick();
      end
      checkOutput("ur_fetch_done", rd_req, 0);
      ack_en = 1'b0;
      tick();

      // Reset in the middle of a fetch
      vpos = 9'd29;
      hpos = 9'd0;
      tick();
      hsync_in = 1'b1;
      ack_en = 1'b1;
      tick();
      checkOutput("rst_fetch_addr", rd_addr, 32'h8f0);
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      checkOutput("rst_after5_addr", rd_addr, 32'h8f5);
      #2;
      reset = 1'b0;
      hsync_in = 1'b0;
      #1;
      checkOutput("rst_rd_req_drop", rd_req, 0);
      checkOutput("rst_rd_addr", rd_addr, 0);
      tick();
      tick();
      #2;
      reset = 1'b1;
      tick();
      tick();
      checkOutput("rst_no_fetch", rd_req, 0);
      display_on = 1'b1;
      hpos = 9'd0;
      tick();
      checkOutput("rst_rgb_invalid", rgb, 4'hc);
      checkOutput("rst_no_underrun", underrun, 0);
      checkOutput("rst_no_fetch_b", rd_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
